// File: rtl/t3maps_seq_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Package     : t3maps_seq_pkg
// Description : Shared types and constants for the T3MAPS command sequencer:
//               FSM state encoding, command-header field layout and the
//               default idle command byte.
// Revision    : 1.0 - initial release
// ============================================================================
package t3maps_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } seq_state_t;

    // Header byte layout: bit 7 = capture enable, bits 6:0 = payload length.
    localparam int unsigned c_hdr_cap_bit = 7;
    localparam int unsigned c_len_w       = 7;

    localparam logic [7:0] c_default_idle_cmd = 8'h00;

    function automatic logic [c_len_w-1:0] hdr_len(input logic [7:0] hdr);
        return hdr[c_len_w-1:0];
    endfunction

    function automatic logic hdr_cap(input logic [7:0] hdr);
        return hdr[c_hdr_cap_bit];
    endfunction

endpackage
`default_nettype wire

// File: rtl/rb_packer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : rb_packer
// Description : Packs the chip's serial response into readback bytes, MSB =
//               first sampled bit. A byte is emitted after every 8th sample
//               and at packet end (partial byte left-aligned, zero-padded).
//               Writes attempted while the readback FIFO is full are dropped
//               and flagged.
// Ports       : clk_5        - 5 MHz clock
//               Reset        - asynchronous active-high reset
//               sample_req   - a payload byte is being registered onto cmd
//               sample_last  - that payload byte is the last of the packet
//               data_in      - serial response from the chip
//               rb_full      - readback FIFO full
//               rb_wr_en     - readback write strobe (registered)
//               rb_din       - readback byte (registered)
//               err_overflow - sticky: a readback byte was dropped
// Revision    : 1.0 - initial release
// ============================================================================
module rb_packer (
    input  logic       clk_5,
    input  logic       Reset,
    input  logic       sample_req,
    input  logic       sample_last,
    input  logic       data_in,
    input  logic       rb_full,
    output logic       rb_wr_en,
    output logic [7:0] rb_din,
    output logic       err_overflow
);

    // Delayed copies of the request: high during the cycle in which cmd
    // actually carries the payload byte, so data_in is taken at the edge
    // that ends that cycle.
    logic       r_sample_en;
    logic       r_sample_last;
    logic [7:0] r_shift;
    logic [2:0] r_bits;

    logic [7:0] w_shift_next;
    logic       w_byte_done;
    logic [7:0] w_packed;

    assign w_shift_next = {r_shift[6:0], data_in};
    assign w_byte_done  = r_sample_en && ((r_bits == 3'd7) || r_sample_last);
    // r_bits samples were held before this one; left-align the total of
    // r_bits+1 samples. A full byte needs no shift.
    assign w_packed     = w_shift_next << (3'd7 - r_bits);

    always_ff @(posedge clk_5 or posedge Reset) begin
        if (Reset) begin
            r_sample_en   <= 1'b0;
            r_sample_last <= 1'b0;
            r_shift       <= 8'h00;
            r_bits        <= 3'd0;
            rb_wr_en      <= 1'b0;
            rb_din        <= 8'h00;
            err_overflow  <= 1'b0;
        end else begin
            r_sample_en   <= sample_req;
            r_sample_last <= sample_last;
            rb_wr_en      <= 1'b0;
            if (r_sample_en) begin
                if (w_byte_done) begin
                    r_shift <= 8'h00;
                    r_bits  <= 3'd0;
                    if (rb_full) begin
                        err_overflow <= 1'b1;
                    end else begin
                        rb_wr_en <= 1'b1;
                        rb_din   <= w_packed;
                    end
                end else begin
                    r_shift <= w_shift_next;
                    r_bits  <= r_bits + 3'd1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/cmd_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : cmd_sequencer
// Description : Pops header-framed command packets from an FWFT command FIFO
//               and drives payload bytes onto the chip's cmd bus one per
//               clock, followed by a fixed idle gap. Optionally captures the
//               chip's serial response into readback bytes. Starts are gated
//               by PLL lock; FIFO underrun and readback overflow are sticky.
// Ports       : clk_5        - 5 MHz clock
//               Reset        - asynchronous active-high reset
//               lock         - PLL lock, gates packet starts
//               cmd_empty    - command FIFO empty
//               cmd_dout     - command FIFO head word (FWFT)
//               cmd_rd_en    - command FIFO pop (combinational)
//               cmd          - registered command byte to chip
//               data_in      - serial response from chip
//               rb_full      - readback FIFO full
//               rb_wr_en     - readback write strobe (registered)
//               rb_din       - readback byte (registered)
//               busy         - packet in progress (SEND or GAP)
//               err_underrun - sticky: FIFO ran empty mid-packet
//               err_overflow - sticky: readback byte dropped
// Revision    : 1.0 - initial release
// ============================================================================
module cmd_sequencer
    import t3maps_seq_pkg::*;
#(
    parameter logic [7:0]  IDLE_CMD   = c_default_idle_cmd,
    parameter int unsigned GAP_CYCLES = 2
) (
    input  logic       clk_5,
    input  logic       Reset,
    input  logic       lock,
    input  logic       cmd_empty,
    input  logic [7:0] cmd_dout,
    output logic       cmd_rd_en,
    output logic [7:0] cmd,
    input  logic       data_in,
    input  logic       rb_full,
    output logic       rb_wr_en,
    output logic [7:0] rb_din,
    output logic       busy,
    output logic       err_underrun,
    output logic       err_overflow
);

    localparam logic [c_len_w-1:0] c_gap_load = c_len_w'(GAP_CYCLES - 1);

    seq_state_t         r_state;
    seq_state_t         w_next_state;
    // Remaining payload bytes in SEND, remaining gap cycles in GAP.
    logic [c_len_w-1:0] r_count;
    logic               r_cap;
    // Holds off header pops until the first clock after reset release so
    // cmd_rd_en is guaranteed low throughout reset.
    logic               r_run;

    logic               w_hdr_pop;
    logic               w_pop_payload;
    logic               w_last_payload;
    logic               w_stall;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_5 or posedge Reset) begin
        if (Reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                // A zero-length header is a NOP: consumed without leaving IDLE.
                if (w_hdr_pop && (hdr_len(cmd_dout) != '0)) begin
                    w_next_state = ST_SEND;
                end
            end
            ST_SEND: begin
                if (w_last_payload) begin
                    w_next_state = ST_GAP;
                end
            end
            ST_GAP: begin
                if (r_count == '0) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output / control decode
    // ------------------------------------------------------------------
    always_comb begin
        w_hdr_pop     = 1'b0;
        w_pop_payload = 1'b0;
        w_stall       = 1'b0;
        busy          = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_hdr_pop = r_run && lock && !cmd_empty;
            end
            ST_SEND: begin
                busy          = 1'b1;
                w_pop_payload = !cmd_empty;
                w_stall       = cmd_empty;
            end
            ST_GAP: begin
                busy = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    assign w_last_payload = w_pop_payload && (r_count == c_len_w'(1));
    assign cmd_rd_en      = w_hdr_pop || w_pop_payload;

    // ------------------------------------------------------------------
    // Packet counter, command byte register and underrun flag
    // ------------------------------------------------------------------
    always_ff @(posedge clk_5 or posedge Reset) begin
        if (Reset) begin
            r_count      <= '0;
            r_cap        <= 1'b0;
            r_run        <= 1'b0;
            cmd          <= IDLE_CMD;
            err_underrun <= 1'b0;
        end else begin
            r_run <= 1'b1;
            cmd   <= w_pop_payload ? cmd_dout : IDLE_CMD;
            if (w_stall) begin
                err_underrun <= 1'b1;
            end
            if (w_hdr_pop) begin
                r_count <= hdr_len(cmd_dout);
                r_cap   <= hdr_cap(cmd_dout);
            end else if (w_last_payload) begin
                r_count <= c_gap_load;
            end else if (w_pop_payload) begin
                r_count <= r_count - c_len_w'(1);
            end else if ((r_state == ST_GAP) && (r_count != '0)) begin
                r_count <= r_count - c_len_w'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Readback capture
    // ------------------------------------------------------------------
    rb_packer u_rb_packer (
        .clk_5        (clk_5),
        .Reset        (Reset),
        .sample_req   (w_pop_payload && r_cap),
        .sample_last  (w_last_payload && r_cap),
        .data_in      (data_in),
        .rb_full      (rb_full),
        .rb_wr_en     (rb_wr_en),
        .rb_din       (rb_din),
        .err_overflow (err_overflow)
    );

endmodule
`default_nettype wire

// File: tb/tb_cmd_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_cmd_sequencer
// Description : Self-checking bench for cmd_sequencer. Directed scenarios
//               plus randomized back-to-back packet streams compared against
//               a packet-level timeline model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cmd_sequencer;

    localparam int GAP  = 2;
    localparam int MAXC = 1024;

    logic       clk_5 = 1'b0;
    logic       Reset = 1'b0;
    logic       lock = 1'b0;
    logic       cmd_empty = 1'b1;
    logic [7:0] cmd_dout = 8'h00;
    logic       data_in = 1'b0;
    logic       rb_full = 1'b0;
    logic       cmd_rd_en;
    logic [7:0] cmd;
    logic       rb_wr_en;
    logic [7:0] rb_din;
    logic       busy;
    logic       err_underrun;
    logic       err_overflow;

    cmd_sequencer #(
        .IDLE_CMD   (8'h00),
        .GAP_CYCLES (GAP)
    ) dut (
        .clk_5        (clk_5),
        .Reset        (Reset),
        .lock         (lock),
        .cmd_empty    (cmd_empty),
        .cmd_dout     (cmd_dout),
        .cmd_rd_en    (cmd_rd_en),
        .cmd          (cmd),
        .data_in      (data_in),
        .rb_full      (rb_full),
        .rb_wr_en     (rb_wr_en),
        .rb_din       (rb_din),
        .busy         (busy),
        .err_underrun (err_underrun),
        .err_overflow (err_overflow)
    );

    always #100 clk_5 = ~clk_5;

    int n_checks = 0;
    int n_fail   = 0;

    // Command FIFO model (FWFT) and per-cycle stimulus/observation arrays.
    logic [7:0] q[$];
    int         cyc;
    logic       din_bits  [MAXC];
    logic       full_bits [MAXC];
    logic [7:0] obs_cmd   [MAXC];
    logic [7:0] obs_din   [MAXC];
    logic       obs_busy  [MAXC];
    logic       obs_rd    [MAXC];
    logic       obs_wr    [MAXC];
    // Expected timeline for the random test.
    logic [7:0] e_cmd  [MAXC];
    logic [7:0] e_din  [MAXC];
    logic       e_busy [MAXC];
    logic       e_rd   [MAXC];
    logic       e_wr   [MAXC];
    logic       exp_ovf;

    task automatic drive();
        int i;
        i = (cyc < MAXC) ? cyc : MAXC - 1;
        cmd_empty = (q.size() == 0);
        cmd_dout  = (q.size() != 0) ? q[0] : 8'($urandom);
        data_in   = din_bits[i];
        rb_full   = full_bits[i];
    endtask

    // One clock: observe mid-cycle, then advance the FIFO model past the edge.
    task automatic step();
        logic rd;
        @(negedge clk_5);
        if (cyc < MAXC) begin
            obs_cmd[cyc]  = cmd;
            obs_busy[cyc] = busy;
            obs_rd[cyc]   = cmd_rd_en;
            obs_wr[cyc]   = rb_wr_en;
            obs_din[cyc]  = rb_din;
        end
        rd = cmd_rd_en;
        @(posedge clk_5);
        #1;
        if (rd && q.size() != 0) void'(q.pop_front());
        cyc++;
        drive();
    endtask

    task automatic begin_test();
        cyc = 0;
        for (int c = 0; c < MAXC; c++) begin
            din_bits[c] = 1'b0; full_bits[c] = 1'b0;
            obs_cmd[c] = 8'h00; obs_din[c] = 8'h00;
            obs_busy[c] = 1'b0; obs_rd[c] = 1'b0; obs_wr[c] = 1'b0;
        end
        drive();
    endtask

    task automatic test_reset();
        #5 Reset = 1'b1;
        @(negedge clk_5);
        n_checks++; if (cmd !== 8'h00) begin n_fail++; $display("FAIL reset_cmd: got %h expected 00", cmd); end
        n_checks++; if (cmd_rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en: got %b expected 0", cmd_rd_en); end
        n_checks++; if (rb_wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_rb_wr_en: got %b expected 0", rb_wr_en); end
        n_checks++; if (rb_din !== 8'h00) begin n_fail++; $display("FAIL reset_rb_din: got %h expected 00", rb_din); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (err_underrun !== 1'b0) begin n_fail++; $display("FAIL reset_err_underrun: got %b expected 0", err_underrun); end
        n_checks++; if (err_overflow !== 1'b0) begin n_fail++; $display("FAIL reset_err_overflow: got %b expected 0", err_overflow); end
        @(posedge clk_5);
        #1;
        Reset = 1'b0;
        lock  = 1'b1;
        begin_test();
        repeat (3) step();
    endtask

    task automatic test_basic();
        logic [7:0] pk [4];
        logic [7:0] ec [10];
        pk = '{8'h03, 8'hA1, 8'hB2, 8'hC3};
        ec = '{8'h00, 8'h00, 8'hA1, 8'hB2, 8'hC3, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        begin_test();
        foreach (pk[i]) q.push_back(pk[i]);
        drive();
        repeat (10) step();
        for (int c = 0; c < 10; c++) begin
            n_checks++;
            if (obs_cmd[c] !== ec[c]) begin n_fail++; $display("FAIL basic_cmd cyc=%0d: got %h expected %h", c, obs_cmd[c], ec[c]); end
            n_checks++;
            if (obs_busy[c] !== (c >= 1 && c <= 5)) begin n_fail++; $display("FAIL basic_busy cyc=%0d: got %b expected %b", c, obs_busy[c], (c >= 1 && c <= 5)); end
            n_checks++;
            if (obs_wr[c] !== 1'b0) begin n_fail++; $display("FAIL basic_no_rb_write cyc=%0d: got %b expected 0", c, obs_wr[c]); end
        end
    endtask

    // Runs one CAP packet and checks it yields exactly one write.
    task automatic test_capture(input logic [7:0] hdr, input int nsamp, input logic [7:0] pattern,
                                input logic [7:0] exp_byte, input int exp_cyc);
        int wr_count, wr_cyc;
        logic [7:0] wr_val;
        begin_test();
        // Bits outside the sampling window are 1 so a misplaced sample shows.
        for (int c = 0; c < 2 + nsamp + 8; c++) din_bits[c] = 1'b1;
        for (int i = 0; i < nsamp; i++) din_bits[2 + i] = pattern[7 - i];
        q.push_back(hdr);
        for (int i = 0; i < int'(hdr[6:0]); i++) q.push_back(8'($urandom));
        drive();
        repeat (nsamp + 8) step();
        wr_count = 0; wr_cyc = -1; wr_val = 8'h00;
        for (int c = 0; c < nsamp + 8; c++) begin
            if (obs_wr[c] === 1'b1) begin wr_count++; wr_cyc = c; wr_val = obs_din[c]; end
        end
        n_checks++; if (wr_count != 1) begin n_fail++; $display("FAIL capture_%h_write_count: got %0d expected 1", hdr, wr_count); end
        n_checks++; if (wr_cyc != exp_cyc) begin n_fail++; $display("FAIL capture_%h_write_cycle: got %0d expected %0d", hdr, wr_cyc, exp_cyc); end
        n_checks++; if (wr_val !== exp_byte) begin n_fail++; $display("FAIL capture_%h_rb_din: got %h expected %h", hdr, wr_val, exp_byte); end
    endtask

    task automatic test_nop();
        begin_test();
        q.push_back(8'h00);
        drive();
        repeat (5) step();
        n_checks++; if (obs_rd[0] !== 1'b1) begin n_fail++; $display("FAIL nop_pop: got %b expected 1", obs_rd[0]); end
        n_checks++; if (q.size() != 0) begin n_fail++; $display("FAIL nop_consumed: got %0d left expected 0", q.size()); end
        for (int c = 0; c < 5; c++) begin
            n_checks++; if (obs_busy[c] !== 1'b0) begin n_fail++; $display("FAIL nop_busy cyc=%0d: got %b expected 0", c, obs_busy[c]); end
        end
    endtask

    task automatic test_lock();
        begin_test();
        lock = 1'b0;
        q.push_back(8'h02); q.push_back(8'hAA); q.push_back(8'hBB);
        drive();
        repeat (5) step();
        for (int c = 0; c < 5; c++) begin
            n_checks++; if (obs_rd[c] !== 1'b0) begin n_fail++; $display("FAIL lock_no_pop cyc=%0d: got %b expected 0", c, obs_rd[c]); end
        end
        n_checks++; if (q.size() != 3) begin n_fail++; $display("FAIL lock_fifo_level: got %0d expected 3", q.size()); end
        lock = 1'b1;
        step();
        // Losing lock after the header pop must not abort the packet.
        lock = 1'b0;
        repeat (6) step();
        n_checks++; if (obs_cmd[7] !== 8'hAA) begin n_fail++; $display("FAIL lock_byte0: got %h expected aa", obs_cmd[7]); end
        n_checks++; if (obs_cmd[8] !== 8'hBB) begin n_fail++; $display("FAIL lock_byte1: got %h expected bb", obs_cmd[8]); end
        n_checks++; if (q.size() != 0) begin n_fail++; $display("FAIL lock_drained: got %0d expected 0", q.size()); end
        lock = 1'b1;
    endtask

    task automatic test_underrun();
        logic [7:0] ec [7];
        ec = '{8'h11, 8'h22, 8'h00, 8'h00, 8'h00, 8'h33, 8'h44};
        n_checks++; if (err_underrun !== 1'b0) begin n_fail++; $display("FAIL underrun_pre: got %b expected 0", err_underrun); end
        begin_test();
        q.push_back(8'h04); q.push_back(8'h11); q.push_back(8'h22);
        drive();
        repeat (12) begin
            step();
            if (cyc == 6) begin q.push_back(8'h33); q.push_back(8'h44); drive(); end
        end
        for (int c = 2; c < 9; c++) begin
            n_checks++; if (obs_cmd[c] !== ec[c-2]) begin n_fail++; $display("FAIL underrun_cmd cyc=%0d: got %h expected %h", c, obs_cmd[c], ec[c-2]); end
        end
        n_checks++; if (obs_busy[5] !== 1'b1) begin n_fail++; $display("FAIL underrun_busy_stall: got %b expected 1", obs_busy[5]); end
        n_checks++; if (err_underrun !== 1'b1) begin n_fail++; $display("FAIL underrun_flag: got %b expected 1", err_underrun); end
    endtask

    task automatic test_overflow();
        int wr_count;
        n_checks++; if (err_overflow !== 1'b0) begin n_fail++; $display("FAIL overflow_pre: got %b expected 0", err_overflow); end
        begin_test();
        for (int c = 0; c < 40; c++) begin full_bits[c] = 1'b1; din_bits[c] = 1'($urandom); end
        q.push_back(8'h90);
        for (int i = 0; i < 16; i++) q.push_back(8'($urandom));
        drive();
        repeat (26) step();
        wr_count = 0;
        for (int c = 0; c < 26; c++) if (obs_wr[c] === 1'b1) wr_count++;
        n_checks++; if (wr_count != 0) begin n_fail++; $display("FAIL overflow_writes: got %0d expected 0", wr_count); end
        n_checks++; if (err_overflow !== 1'b1) begin n_fail++; $display("FAIL overflow_flag: got %b expected 1", err_overflow); end
        full_bits[26] = 1'b0;
        drive();
    endtask

    task automatic test_reset_mid();
        begin_test();
        for (int c = 0; c < 20; c++) din_bits[c] = 1'b1;
        q.push_back(8'h85);
        for (int i = 1; i <= 5; i++) q.push_back(8'(i));
        drive();
        repeat (4) step();
        Reset = 1'b1;
        @(negedge clk_5);
        n_checks++; if (cmd !== 8'h00) begin n_fail++; $display("FAIL rstmid_cmd: got %h expected 00", cmd); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
        n_checks++; if (cmd_rd_en !== 1'b0) begin n_fail++; $display("FAIL rstmid_rd_en: got %b expected 0", cmd_rd_en); end
        n_checks++; if (q.size() != 2) begin n_fail++; $display("FAIL rstmid_fifo_left: got %0d expected 2", q.size()); end
        n_checks++; if (err_underrun !== 1'b0) begin n_fail++; $display("FAIL rstmid_err_underrun: got %b expected 0", err_underrun); end
        n_checks++; if (err_overflow !== 1'b0) begin n_fail++; $display("FAIL rstmid_err_overflow: got %b expected 0", err_overflow); end
        @(posedge clk_5);
        #1;
        Reset = 1'b0;
        q.delete();
        begin_test();
        repeat (3) step();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_idle_after: got busy %b expected 0", busy); end
    endtask

    // Random back-to-back streams; expectations come from packet arithmetic:
    // header at t, byte i on cmd at t+2+i, sample at end of t+2+i, write one
    // cycle later, next header at t+1+N+GAP (t+1 for a NOP).
    task automatic test_random();
        logic [7:0] s[$];
        logic [7:0] acc, val;
        logic       cap;
        int         t, n, idx, cnt, tend;
        exp_ovf = 1'b0;
        for (int round = 0; round < 3; round++) begin
            begin_test();
            s.delete();
            for (int p = 0; p < 8; p++) begin
                n = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 20));
                s.push_back({1'($urandom_range(0, 1)), 7'(n)});
                for (int i = 0; i < n; i++) s.push_back(8'($urandom));
            end
            for (int c = 0; c < MAXC; c++) begin
                din_bits[c] = 1'($urandom);
                full_bits[c] = ($urandom_range(0, 7) == 0);
                e_cmd[c] = 8'h00; e_din[c] = 8'h00; e_busy[c] = 1'b0; e_rd[c] = 1'b0; e_wr[c] = 1'b0;
            end
            t = 0; idx = 0;
            while (idx < s.size()) begin
                n   = int'(s[idx][6:0]);
                cap = s[idx][7];
                e_rd[t] = 1'b1;
                if (n == 0) begin
                    t = t + 1;
                end else begin
                    for (int i = 0; i < n; i++) begin
                        e_rd[t+1+i]  = 1'b1;
                        e_cmd[t+2+i] = s[idx+1+i];
                    end
                    for (int c = t + 1; c <= t + n + GAP; c++) e_busy[c] = 1'b1;
                    if (cap) begin
                        acc = 8'h00; cnt = 0;
                        for (int i = 0; i < n; i++) begin
                            acc = {acc[6:0], din_bits[t+2+i]};
                            cnt++;
                            if (cnt == 8 || i == n - 1) begin
                                val = acc << (8 - cnt);
                                if (full_bits[t+2+i]) exp_ovf = 1'b1;
                                else begin e_wr[t+3+i] = 1'b1; e_din[t+3+i] = val; end
                                acc = 8'h00; cnt = 0;
                            end
                        end
                    end
                    t = t + 1 + n + GAP;
                end
                idx = idx + 1 + n;
            end
            tend = t + 4;
            foreach (s[i]) q.push_back(s[i]);
            drive();
            while (cyc < tend) step();
            for (int c = 0; c < tend; c++) begin
                n_checks++; if (obs_cmd[c] !== e_cmd[c]) begin n_fail++; $display("FAIL random_cmd r=%0d cyc=%0d: got %h expected %h", round, c, obs_cmd[c], e_cmd[c]); end
                n_checks++; if (obs_busy[c] !== e_busy[c]) begin n_fail++; $display("FAIL random_busy r=%0d cyc=%0d: got %b expected %b", round, c, obs_busy[c], e_busy[c]); end
                n_checks++; if (obs_rd[c] !== e_rd[c]) begin n_fail++; $display("FAIL random_rd_en r=%0d cyc=%0d: got %b expected %b", round, c, obs_rd[c], e_rd[c]); end
                n_checks++; if (obs_wr[c] !== e_wr[c]) begin n_fail++; $display("FAIL random_rb_wr_en r=%0d cyc=%0d: got %b expected %b", round, c, obs_wr[c], e_wr[c]); end
                if (e_wr[c]) begin
                    n_checks++; if (obs_din[c] !== e_din[c]) begin n_fail++; $display("FAIL random_rb_din r=%0d cyc=%0d: got %h expected %h", round, c, obs_din[c], e_din[c]); end
                end
            end
        end
        n_checks++; if (err_overflow !== exp_ovf) begin n_fail++; $display("FAIL random_err_overflow: got %b expected %b", err_overflow, exp_ovf); end
        n_checks++; if (err_underrun !== 1'b0) begin n_fail++; $display("FAIL random_err_underrun: got %b expected 0", err_underrun); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_capture(8'h88, 8, 8'b1011_0010, 8'hB2, 10);
        test_capture(8'h83, 3, 8'b1110_0000, 8'hE0, 5);
        test_nop();
        test_lock();
        test_underrun();
        test_overflow();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/cmd_sequencer.md
# cmd_sequencer

Packet sequencer between the command FIFO read port and the T3MAPS chip, in the 5 MHz domain. Pops header-framed command packets from a first-word-fall-through FIFO, drives payload bytes onto the 8-bit `cmd` bus one per clock, and optionally packs the chip's serial `data_in` response into bytes for the readback FIFO. Gates all activity on PLL lock and flags FIFO underrun/overflow to the LED/status logic.

## Interface
Parameters:
- `IDLE_CMD`, 8'h00, value driven on `cmd` when no payload byte is active.
- `GAP_CYCLES`, 2, idle cycles inserted after each packet; legal range 1..15.

Ports:
- `clk_5`  in  1  5 MHz clock; the only clock.
- `Reset`  in  1  asynchronous, active-high reset.
- `lock`  in  1  PLL lock; a packet starts only while high.
- `cmd_empty`  in  1  command FIFO empty.
- `cmd_dout`  in  8  command FIFO head word (FWFT, valid when `cmd_empty`=0).
- `cmd_rd_en`  out  1  pop command FIFO; combinational.
- `cmd`  out  8  registered command byte to chip.
- `data_in`  in  1  serial response from chip.
- `rb_full`  in  1  readback FIFO full.
- `rb_wr_en`  out  1  readback write strobe, registered.
- `rb_din`  out  8  readback byte, registered, MSB = first sampled bit.
- `busy`  out  1  packet in progress (SEND or GAP).
- `err_underrun`  out  1  sticky; FIFO empty mid-packet.
- `err_overflow`  out  1  sticky; readback byte dropped.

## Operation
- Header byte: bit 7 = CAP (capture enable), bits 6:0 = N payload bytes. N=0 is a NOP: header consumed, no output, stay IDLE.
- States: IDLE, SEND, GAP.
- IDLE: `cmd`=IDLE_CMD. If `lock` && !`cmd_empty`: assert `cmd_rd_en`, latch N and CAP; go SEND if N≠0.
- SEND: if !`cmd_empty`: assert `cmd_rd_en`, register `cmd_dout` onto `cmd`, decrement remaining count; on the last byte go GAP. If `cmd_empty`: stall, `cmd`=IDLE_CMD, set `err_underrun`; resume when data arrives, no byte skipped.
- GAP: `cmd`=IDLE_CMD for GAP_CYCLES cycles, then IDLE.
- Capture (CAP=1): a registered flag marks each cycle in which `cmd` carries a payload byte; `data_in` is sampled on the rising edge ending that cycle and shifted MSB-first. Every 8th sample produces a write of the packed byte. At packet end, a partial byte (N mod 8 ≠ 0) is written left-aligned, zero-padded in the low bits.
- Readback write with `rb_full`=1: byte dropped, `err_overflow` set, packing continues.
- Sticky errors clear only on `Reset`.
- `lock` dropping mid-packet does not abort; it blocks only the next start.
- Reset mid-packet: immediate return to IDLE, partial capture discarded; unread packet bytes remain in the FIFO (the host resets the FIFO as well).

## Timing
- Reset values: `cmd`=IDLE_CMD; `cmd_rd_en`, `rb_wr_en`, `busy`, `err_*` = 0; `rb_din`=8'h00; state IDLE.
- Header popped in cycle t. Payload byte i (0-based, no stalls) is popped in t+1+i and is on `cmd` during t+2+i. `data_in` is sampled at the end of t+2+i.
- `busy` is high from t+1 through the last GAP cycle.
- `rb_wr_en` pulses one cycle, in the cycle after the 8th (or final partial) sample.
- Back-to-back packets: next header pop occurs in the first IDLE cycle after GAP. Minimum packet period is 1+N+GAP_CYCLES cycles.

## Structure
- Package `t3maps_seq_pkg`: state enum; header field constants (CAP bit 7, LEN bits 6:0); default IDLE_CMD.
- Sub-module `rb_packer`: the sample shift register, bit counter, flush-on-end, and rb write/overflow logic.
- The top of the block holds the FSM and packet counter.

## Test plan
- Header 8'h03, payload A1 B2 C3, lock=1, FIFO never empty -> `cmd` shows A1, B2, C3 in consecutive cycles t+2..t+4, then 00 for 2 cycles; no `rb_wr_en`; `busy` high for 5 cycles.
- Header 8'h88, 8 payload bytes, `data_in` pattern 1,0,1,1,0,0,1,0 -> single `rb_wr_en` with `rb_din`=8'hB2.
- Header 8'h83, `data_in`=1,1,1 -> `rb_din`=8'hE0 written at packet end.
- FIFO empties after the 2nd of 4 payload bytes for 3 cycles -> `cmd`=00 for 3 cycles, `err_underrun`=1, all 4 bytes still emitted in order.
- CAP packet of 16 bytes with `rb_full`=1 throughout -> no accepted writes, `err_overflow`=1. Separately, header 8'h00 -> consumed, `busy` stays 0.
- lock=0 with FIFO non-empty -> no pop. Assert `Reset` at byte 2 of 5 -> `cmd`=00, `busy`=0, state IDLE on the next edge.
